mem_param: RTL and testbench
============================

# mem_param

Parametrised single-port synchronous memory, the next generation of the CPU's 8x32 data/program memory. Word width and address width are parameters, reads return a one-cycle `rd_valid` strobe, illegal accesses raise a sticky error flag, and an optional hardware clear sequencer zeroes the whole array after reset or on request. It sits between the VeriRISC controller/address mux and the data bus, in place of the fixed-size memory.

## Interface
- `DWIDTH`, default 8: data word width in bits (>=1).
- `AWIDTH`, default 5: address width; `DEPTH` = 2**AWIDTH is a derived localparam.
- `clk`  in  1: single clock, all activity on rising edge.
- `rst_`  in  1: reset, synchronous and active-low.
- `read`  in  1: read request for `addr`.
- `write`  in  1: write request of `data_in` to `addr`.
- `addr`  in  AWIDTH: word address, 0..DEPTH-1.
- `data_in`  in  DWIDTH: write data.
- `clr`  in  1: single-cycle request to start a clear sweep.
- `data_out`  out  DWIDTH: registered read data; holds its value between reads.
- `rd_valid`  out  1: high for exactly one cycle after an accepted read.
- `busy`  out  1: clear sweep in progress; all accesses are rejected.
- `err`  out  1: sticky illegal-access flag.

## Operation
- FSM states: CLEAR (sweep running, `busy`=1) and IDLE (`busy`=0).
- Reset (`rst_`=0 at an edge):
  - `data_out`=0, `rd_valid`=0, `err`=0, sweep counter=0.
  - State becomes CLEAR, so `busy`=1.
  - Array contents are not touched during reset itself.
- CLEAR, one word per rising edge with `rst_`=1:
  - memory[cnt] <= 0 and cnt increments.
  - After writing address DEPTH-1, the state becomes IDLE.
- IDLE, read only (`read`=1, `write`=0): `data_out` <= memory[addr] and `rd_valid`=1 for the following cycle.
- IDLE, write only (`write`=1, `read`=0): memory[addr] <= `data_in`. `data_out` is unchanged and `rd_valid`=0.
- IDLE, `read` and `write` both 1: no access is performed, `err` <= 1 and `rd_valid`=0.
- Any `read` or `write` while `busy`=1: the access is dropped and `err` <= 1.
- `clr`=1 in IDLE:
  - State becomes CLEAR, cnt=0 and `err` <= 0.
  - Any access in the same cycle is dropped silently (`clr` has priority and `err` stays clear).
- `clr`=1 while in CLEAR: ignored; the sweep continues from the current cnt.
- `err` is cleared only by reset or an accepted `clr`.
- `data_out` is never modified by a sweep, so it keeps the last read value.
- Address arithmetic is modulo DEPTH. No out-of-range address exists.

## Timing
- Read latency is 1 cycle: request at edge N, and `data_out`/`rd_valid` are valid after edge N.
- Write is visible to a read issued at the next edge (read-after-write on consecutive cycles returns the new data).
- Sweep length is exactly DEPTH rising edges with `rst_`=1. `busy` falls after the DEPTH-th edge, and the first access can be accepted on the next edge.
- Reset asserted mid-sweep or mid-access: reset wins at that edge, the sweep restarts from address 0, and a pending `rd_valid` is cleared.
- Back-to-back reads give `rd_valid` continuously high, with new data every cycle.

## Configuration
- Macro `MEM_CLEAR_EN`.
- Defined: the clear sequencer is present exactly as described above.
- Undefined:
  - No CLEAR state. After reset the block is immediately IDLE and `busy` is tied to 0.
  - `clr` is ignored. The `err` clear path is reset only.
  - Array contents after power-up are undefined (X in simulation).
  - All other behaviour is unchanged.

## Test plan
- Reset then sweep (DWIDTH=8, AWIDTH=5, `MEM_CLEAR_EN`): deassert `rst_` -> `busy`=1 for exactly 32 edges. Then reading addresses 0..31 gives 0x00 each, with `rd_valid` one cycle after each request.
- Write/read: write 0xA5 to 3, then read 3 on the next edge -> `data_out`=0xA5 and `rd_valid`=1 for one cycle. `data_out` holds 0xA5 afterwards.
- Conflict: `read`=`write`=1 at addr 7 with `data_in`=0xFF -> memory[7] unchanged, `rd_valid`=0 and `err`=1 sticky. A following `clr` -> `err`=0.
- Access while busy: write 0x11 to addr 2 during the sweep -> dropped, `err`=1, and memory[2] reads 0x00 after the sweep.
- Reset mid-sweep: assert `rst_`=0 at sweep edge 10 -> `busy` stays 1 and the sweep restarts, finishing 32 edges after release.
- Parameter corner (DWIDTH=16, AWIDTH=2, macro undefined): no busy period. Write 0xBEEF to addr 3 and read it back -> 0xBEEF. Write to addr 0 does not alias to addr 3.

Source files
------------

// File: rtl/mem_param.sv
// Parametrised single-port synchronous memory with registered reads, rd_valid strobe and sticky error flag.
// Define MEM_CLEAR_EN to build the hardware clear sequencer that zeroes the array after reset or on clr.
module mem_param #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              read,
  input  logic              write,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              clr,
  output logic [DWIDTH-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              err
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [DWIDTH-1:0] data_out_q, data_out_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;

  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;

  logic              sweep_on;
  logic [AWIDTH-1:0] sweep_addr;
  logic              clr_go;

`ifdef MEM_CLEAR_EN
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;

  // NOTE: sequential state uses <= only; always_comb blocks use = with every output defaulted first, so no latches.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A clr during the sweep is ignored; the counter just runs to the top address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_go  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = ST_IDLE;
      end
      default: begin
        if (clr) begin
          clr_go  = 1'b1;
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign sweep_on   = (state_q == ST_CLEAR);
  assign sweep_addr = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr;

  assign sweep_on   = 1'b0;
  assign sweep_addr = '0;
  assign clr_go     = 1'b0;
`endif

  // The sweep owns the write port while busy; user accesses are then dropped and flagged.
  always_comb begin
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_waddr  = addr;
    mem_wdata  = data_in;
    if (sweep_on) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_addr;
      mem_wdata = '0;
      if (read || write) err_d = 1'b1;
    end else if (clr_go) begin
      err_d = 1'b0;
    end else if (read && write) begin
      err_d = 1'b1;
    end else if (read) begin
      data_out_d = mem_q[addr];
      rd_valid_d = 1'b1;
    end else if (write) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; reset only blocks writes at that edge.
  always_ff @(posedge clk) begin
    if (rst_ && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign busy     = sweep_on;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_param.sv
// Directed self-checking bench for mem_param: an 8x32 instance and a 16x4 corner instance.
// Expectations adapt to whether MEM_CLEAR_EN is defined.
module tb_mem_param;

`ifdef MEM_CLEAR_EN
  localparam int SWEEP_A = 32;
  localparam bit CLR_EN  = 1'b1;
`else
  localparam int SWEEP_A = 0;
  localparam bit CLR_EN  = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  logic       rd_a, wr_a, clr_a;
  logic [4:0] addr_a;
  logic [7:0] din_a, dout_a;
  logic       rv_a, busy_a, err_a;

  logic        rd_b, wr_b, clr_b;
  logic [1:0]  addr_b;
  logic [15:0] din_b, dout_b;
  logic        rv_b, busy_b, err_b;

  mem_param #(.DWIDTH(8), .AWIDTH(5)) u_dut (
    .clk(clk), .rst_(rst_), .read(rd_a), .write(wr_a), .addr(addr_a),
    .data_in(din_a), .clr(clr_a), .data_out(dout_a), .rd_valid(rv_a),
    .busy(busy_a), .err(err_a)
  );

  mem_param #(.DWIDTH(16), .AWIDTH(2)) u_dut16 (
    .clk(clk), .rst_(rst_), .read(rd_b), .write(wr_b), .addr(addr_b),
    .data_in(din_b), .clr(clr_b), .data_out(dout_b), .rd_valid(rv_b),
    .busy(busy_b), .err(err_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] mem_m [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int i);
    pat = 8'((i * 9) + 60);
  endfunction

  task automatic wait_sweep(input string tag, input int exp_edges);
    int n;
    n = 0;
    while (busy_a && n < 100) begin
      tick();
      n++;
    end
    check(tag, n, exp_edges);
  endtask

  task automatic read_a(input string tag, input int a, input logic [7:0] exp);
    rd_a = 1'b1; addr_a = 5'(a);
    tick();
    rd_a = 1'b0;
    check({tag, "_data"}, dout_a, exp);
    check({tag, "_rv"}, rv_a, 1'b1);
  endtask

  initial begin
    rst_ = 1'b0;
    rd_a = 0; wr_a = 0; clr_a = 0; addr_a = '0; din_a = '0;
    rd_b = 0; wr_b = 0; clr_b = 0; addr_b = '0; din_b = '0;

    // Reset state
    tick(); tick();
    check("rst_dout", dout_a, 8'h00);
    check("rst_rv", rv_a, 1'b0);
    check("rst_err", err_a, 1'b0);
    check("rst_busy", busy_a, CLR_EN);
    check("rst_busy16", busy_b, 1'b0 | CLR_EN);

    // Release and measure the sweep length
    rst_ = 1'b1;
    wait_sweep("sweep_len", SWEEP_A);
    check("post_sweep_err", err_a, 1'b0);
    check("busy16_idle", busy_b, 1'b0);

`ifdef MEM_CLEAR_EN
    for (int i = 0; i < 32; i++) begin
      rd_a = 1'b1; addr_a = 5'(i);
      tick();
      check("zero_rd", dout_a, 8'h00);
      check("zero_rv", rv_a, 1'b1);
    end
    rd_a = 1'b0;
`endif

    // Fill with a pattern, then back-to-back read-back
    for (int i = 0; i < 32; i++) begin
      wr_a = 1'b1; addr_a = 5'(i); din_a = pat(i); mem_m[i] = pat(i);
      tick();
    end
    wr_a = 1'b0;
    check("wr_rv_low", rv_a, 1'b0);
    for (int i = 0; i < 32; i++) begin
      rd_a = 1'b1; addr_a = 5'(i);
      tick();
      check("b2b_data", dout_a, mem_m[i]);
      check("b2b_rv", rv_a, 1'b1);
    end
    rd_a = 1'b0;
    tick();
    check("b2b_rv_drop", rv_a, 1'b0);
    check("b2b_hold", dout_a, pat(31));

    // Write 0xA5 to 3, read it on the very next edge
    wr_a = 1'b1; addr_a = 5'd3; din_a = 8'hA5; mem_m[3] = 8'hA5;
    tick();
    wr_a = 1'b0;
    check("wr_keeps_dout", dout_a, pat(31));
    check("wr_rv", rv_a, 1'b0);
    read_a("raw", 3, 8'hA5);
    tick();
    check("raw_rv_drop", rv_a, 1'b0);
    check("raw_hold", dout_a, 8'hA5);

    // Simultaneous read and write
    rd_a = 1'b1; wr_a = 1'b1; addr_a = 5'd7; din_a = 8'hFF;
    tick();
    rd_a = 1'b0; wr_a = 1'b0;
    check("conf_rv", rv_a, 1'b0);
    check("conf_err", err_a, 1'b1);
    check("conf_dout", dout_a, 8'hA5);
    tick();
    check("conf_sticky", err_a, 1'b1);
    read_a("conf_mem7", 7, pat(7));
    check("conf_sticky2", err_a, 1'b1);

    // clr with a same-cycle write
    clr_a = 1'b1; wr_a = 1'b1; addr_a = 5'd9; din_a = 8'h77;
    tick();
    clr_a = 1'b0; wr_a = 1'b0;
`ifdef MEM_CLEAR_EN
    check("clr_err", err_a, 1'b0);
    check("clr_busy", busy_a, 1'b1);
    wr_a = 1'b1; addr_a = 5'd2; din_a = 8'h11;
    tick();
    wr_a = 1'b0;
    check("busy_wr_err", err_a, 1'b1);
    begin
      int n;
      n = 1;
      while (busy_a && n < 100) begin
        tick();
        n++;
      end
      check("clr_sweep_len", n, 32);
    end
    for (int i = 0; i < 32; i++) mem_m[i] = 8'h00;
    read_a("busy_wr_drop", 2, 8'h00);
    read_a("clr_wr_drop", 9, 8'h00);
    check("err_after_sweep", err_a, 1'b1);
    wr_a = 1'b1; addr_a = 5'd4; din_a = 8'h5C;
    tick();
    wr_a = 1'b0;
    read_a("pre_rst_rd", 4, 8'h5C);
    // Start a sweep and hit reset on its 10th edge
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    check("clr2_err", err_a, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    check("mid_sweep_busy", busy_a, 1'b1);
`else
    check("clr_ignored_err", err_a, 1'b1);
    check("clr_ignored_busy", busy_a, 1'b0);
    mem_m[9] = 8'h77;
    read_a("clr_ignored_wr", 9, 8'h77);
`endif

    // Reset with a read pending
    rst_ = 1'b0; rd_a = 1'b1; addr_a = 5'd3;
    tick();
    rst_ = 1'b1; rd_a = 1'b0;
    check("rst2_rv", rv_a, 1'b0);
    check("rst2_dout", dout_a, 8'h00);
    check("rst2_err", err_a, 1'b0);
    check("rst2_busy", busy_a, CLR_EN);
    wait_sweep("rst2_sweep_len", SWEEP_A);
    read_a("rst2_mem3", 3, CLR_EN ? 8'h00 : 8'hA5);

    // 16-bit / 4-word corner instance
    check("c16_busy", busy_b, 1'b0);
    wr_b = 1'b1; addr_b = 2'd3; din_b = 16'hBEEF;
    tick();
    addr_b = 2'd0; din_b = 16'h1234;
    tick();
    wr_b = 1'b0; rd_b = 1'b1; addr_b = 2'd3;
    tick();
    check("c16_rd3", dout_b, 16'hBEEF);
    check("c16_rv3", rv_b, 1'b1);
    addr_b = 2'd0;
    tick();
    rd_b = 1'b0;
    check("c16_rd0", dout_b, 16'h1234);
    check("c16_err", err_b, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
